// File: rtl/i2s_pkg.sv
// Shared constants, FSM state type and lrclk helper for the I2S transceiver.
package i2s_pkg;

    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned SLOT_BITS  = 32;

    // Bit-counter landmarks within a 64-bit frame
    localparam logic [5:0] BIT_LAST      = 6'(FRAME_BITS - 1);
    localparam logic [5:0] BIT_PREFETCH  = 6'(FRAME_BITS - 2);
    localparam logic [5:0] LR_HIGH_FIRST = 6'(SLOT_BITS - 1);
    localparam logic [5:0] LR_HIGH_LAST  = 6'(FRAME_BITS - 2);

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StLoad,
        StRun,
        StStop
    } i2s_state_e;

    // lrclk leads the right slot by one bit (standard I2S delay)
    function automatic logic lr_for_bit(input logic [5:0] bit_idx);
        return (bit_idx >= LR_HIGH_FIRST) && (bit_idx <= LR_HIGH_LAST);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: registered bclk plus one-clk rise/fall event strobes that
// are high in the clk cycle whose closing edge toggles bclk.
module i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_bclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             w_wrap;

    assign w_wrap = i_run && !i_clear && (r_div_cnt == DIV_LAST);
    assign o_rise = w_wrap && !r_bclk;
    assign o_fall = w_wrap && r_bclk;
    assign o_bclk = r_bclk;

    // Count clk cycles per half-period and toggle bclk on wrap
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (i_clear) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (i_run) begin
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_shift_transceiver.sv
// I2S bus master: serialises playback FIFO words onto sdata_out and assembles
// sdata_in into capture FIFO words. Frame = {left[31:0], right[31:0]}, MSB first.
module i2s_shift_transceiver
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic [63:0] i_playback_fifo_data,
    input  logic        i_playback_fifo_empty,
    output logic        o_playback_fifo_read,
    output logic [63:0] o_capture_fifo_data,
    input  logic        i_capture_fifo_full,
    output logic        o_capture_fifo_write,
    output logic        o_bclk,
    output logic        o_lrclk,
    output logic        o_sdata_out,
    input  logic        i_sdata_in,
    output logic        o_tx_underrun,
    output logic        o_rx_overrun
);

    i2s_state_e  r_state;
    logic [5:0]  r_bit_cnt;
    logic        r_lrclk;
    logic [63:0] r_tx_shift;
    logic [63:0] r_next_word;
    logic        r_prime_empty;
    logic        r_read;
    logic        r_read_d;
    logic        r_underrun;
    logic [63:0] r_rx_shift;
    logic        r_rx_done;
    logic [63:0] r_cap_data;
    logic        r_write;
    logic        r_overrun;

    logic        w_run;
    logic        w_rise;
    logic        w_fall;

    assign w_run = (r_state == StRun) || (r_state == StStop);

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_run     (w_run),
        .i_clear   (!w_run),
        .o_bclk    (o_bclk),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign o_lrclk              = r_lrclk;
    assign o_sdata_out          = r_tx_shift[FRAME_BITS-1];
    assign o_playback_fifo_read = r_read;
    assign o_tx_underrun        = r_underrun;
    assign o_capture_fifo_data  = r_cap_data;
    assign o_capture_fifo_write = r_write;
    assign o_rx_overrun         = r_overrun;

    // Control FSM: frame sequencing, TX shifting, bit counter and playback prefetch
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_bit_cnt     <= '0;
            r_lrclk       <= 1'b0;
            r_tx_shift    <= '0;
            r_next_word   <= '0;
            r_prime_empty <= 1'b0;
            r_read        <= 1'b0;
            r_read_d      <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_read     <= 1'b0;
            r_underrun <= 1'b0;
            r_read_d   <= r_read;
            // FIFO q is valid the clk after the read strobe
            if (r_read_d) begin
                r_next_word <= i_playback_fifo_data;
            end
            unique case (r_state)
                StIdle: begin
                    if (i_enable) begin
                        r_state       <= StPrime;
                        r_prime_empty <= i_playback_fifo_empty;
                        if (!i_playback_fifo_empty) begin
                            r_read <= 1'b1;
                        end else begin
                            r_underrun <= 1'b1;
                        end
                    end
                end
                StPrime: begin
                    r_state <= StLoad;
                end
                StLoad: begin
                    r_tx_shift <= r_prime_empty ? '0 : i_playback_fifo_data;
                    r_bit_cnt  <= '0;
                    r_lrclk    <= 1'b0;
                    r_state    <= StRun;
                end
                StRun, StStop: begin
                    if (w_fall) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_lrclk   <= 1'b0;
                            if (r_state == StStop) begin
                                r_tx_shift <= '0;
                                r_state    <= StIdle;
                            end else begin
                                r_tx_shift <= r_next_word;
                            end
                        end else begin
                            r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
                            r_bit_cnt  <= r_bit_cnt + 6'd1;
                            r_lrclk    <= lr_for_bit(r_bit_cnt + 6'd1);
                            // Entering bit 63: decide whether another frame follows
                            if (r_bit_cnt == BIT_PREFETCH) begin
                                if (!i_enable) begin
                                    r_state <= StStop;
                                end else if (!i_playback_fifo_empty) begin
                                    r_read <= 1'b1;
                                end else begin
                                    r_underrun  <= 1'b1;
                                    r_next_word <= '0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // RX: shift on bclk rise, hand the full frame to the capture FIFO one clk later
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_shift <= '0;
            r_rx_done  <= 1'b0;
            r_cap_data <= '0;
            r_write    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_write   <= 1'b0;
            r_overrun <= 1'b0;
            r_rx_done <= 1'b0;
            if (w_rise) begin
                r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], i_sdata_in};
                r_rx_done  <= (r_bit_cnt == BIT_LAST);
            end
            if (r_rx_done) begin
                if (!i_capture_fifo_full) begin
                    r_cap_data <= r_rx_shift;
                    r_write    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

endmodule
